// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake, output holding register and iterative multiply.
// Optional ALU_PIPE_STICKY_OVF_EN adds a sticky overflow flag with its clear input.
module alu_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic [3:0]       command,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryout,
  output logic             zero,
  output logic             overflow,
  output logic             busy
`ifdef ALU_PIPE_STICKY_OVF_EN
  ,
  input  logic             sticky_clr,
  output logic             sticky_ovf
`endif
);
  localparam int SHW = $clog2(WIDTH);
  localparam int M = WIDTH - 1;
  localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);
  localparam logic [WIDTH:0] ONE = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, HOLD, ST_MUL} state_t;
  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             c;
    logic             z;
    logic             o;
  } alu_rsp_t;

  state_t state, state_nx;
  alu_rsp_t alu_rsp, mul_rsp, out_q;
  logic [WIDTH:0] sum, dif;
  logic ovf_add, ovf_sub, accept, is_mul;
  logic load_alu, load_mul, start_mul;
  logic [SHW-1:0] sh, cnt;
  logic [2*WIDTH-1:0] acc, acc_nx, mcand;
  logic [WIDTH-1:0] mplier;

  assign sh      = operandB[SHW-1:0];
  assign sum     = {1'b0, operandA} + {1'b0, operandB};
  assign dif     = {1'b0, operandA} + {1'b0, ~operandB} + ONE;
  assign ovf_add = (operandA[M] == operandB[M]) && (sum[M] != operandA[M]);
  assign ovf_sub = (operandA[M] != operandB[M]) && (dif[M] != operandA[M]);

  always_comb begin
    alu_rsp = '0;
    case (command)
      4'b0000: begin alu_rsp.res = sum[WIDTH-1:0]; alu_rsp.c = sum[WIDTH]; alu_rsp.o = ovf_add; end
      4'b0001: begin alu_rsp.res = dif[WIDTH-1:0]; alu_rsp.c = dif[WIDTH]; alu_rsp.o = ovf_sub; end
      4'b0010: alu_rsp.res = operandA ^ operandB;
      4'b0011: alu_rsp.res = {{(WIDTH-1){1'b0}}, dif[M] ^ ovf_sub};
      4'b0100: alu_rsp.res = operandA & operandB;
      4'b0101: alu_rsp.res = ~(operandA & operandB);
      4'b0110: alu_rsp.res = ~(operandA | operandB);
      4'b0111: alu_rsp.res = operandA | operandB;
      4'b1000: alu_rsp.res = operandA << sh;
      4'b1001: alu_rsp.res = operandA >> sh;
      4'b1010: alu_rsp.res = $signed(operandA) >>> sh;
      default: alu_rsp.res = '0;
    endcase
    alu_rsp.z = (alu_rsp.res == '0);
  end

  // One partial product per cycle; acc_nx on the last count is the full product.
  assign acc_nx = acc + (mplier[0] ? mcand : '0);
  always_comb begin
    mul_rsp     = '0;
    mul_rsp.res = acc_nx[WIDTH-1:0];
    mul_rsp.o   = |acc_nx[2*WIDTH-1:WIDTH];
    mul_rsp.z   = (acc_nx[WIDTH-1:0] == '0);
  end

  assign in_ready  = (state == IDLE) || ((state == HOLD) && out_ready);
  assign accept    = in_valid && in_ready;
  assign is_mul    = (command == 4'b1011);
  assign out_valid = (state == HOLD);
  assign busy      = (state == ST_MUL);

  always_comb begin
    state_nx  = state;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    start_mul = 1'b0;
    case (state)
      IDLE, HOLD: begin
        if (accept) begin
          if (is_mul) begin state_nx = ST_MUL; start_mul = 1'b1; end
          else begin state_nx = HOLD; load_alu = 1'b1; end
        end else if (state == HOLD && out_ready) begin
          state_nx = IDLE;
        end
      end
      ST_MUL: if (cnt == LAST) begin state_nx = HOLD; load_mul = 1'b1; end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      out_q  <= '0;
    end else begin
      state <= state_nx;
      if (start_mul) begin
        cnt    <= '0;
        acc    <= '0;
        mcand  <= {{WIDTH{1'b0}}, operandA};
        mplier <= operandB;
      end else if (state == ST_MUL) begin
        cnt    <= (cnt == LAST) ? '0 : cnt + SHW'(1);
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
      end
      if (load_alu) out_q <= alu_rsp;
      else if (load_mul) out_q <= mul_rsp;
    end
  end

  assign result   = out_q.res;
  assign carryout = out_q.c;
  assign zero     = out_q.z;
  assign overflow = out_q.o;

`ifdef ALU_PIPE_STICKY_OVF_EN
  logic ld_ovf;
  assign ld_ovf = (load_alu && alu_rsp.o) || (load_mul && mul_rsp.o);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_ovf <= 1'b0;
    else if (ld_ovf) sticky_ovf <= 1'b1;
    else if (sticky_clr) sticky_ovf <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe at WIDTH=8: expected results queued on accept, checked on output handshake.
module tb_alu_pipe;
  localparam int W = 8;
  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic [W-1:0] a_i = '0, b_i = '0;
  logic [3:0] cmd = '0;
  logic in_ready, out_valid, carryout, zero, overflow, busy;
  logic [W-1:0] result;
`ifdef ALU_PIPE_STICKY_OVF_EN
  logic sticky_clr = 1'b0, sticky_ovf;
`endif

  typedef struct packed {logic [W-1:0] r; logic c; logic z; logic o;} exp_t;
  exp_t sbq[$];
  int n_chk = 0, n_err = 0, cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_pipe #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .operandA(a_i), .operandB(b_i), .command(cmd), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .carryout(carryout), .zero(zero),
    .overflow(overflow), .busy(busy)
`ifdef ALU_PIPE_STICKY_OVF_EN
    , .sticky_clr(sticky_clr), .sticky_ovf(sticky_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    exp_t e;
    int sa, sb, s, ua, ub, p, sh;
    e = '0;
    sa = $signed(a); sb = $signed(b); ua = int'(a); ub = int'(b); sh = int'(b[2:0]);
    case (c)
      4'd0: begin s = sa + sb; e.r = 8'(ua + ub); e.c = (ua + ub) > 255; e.o = (s > 127) || (s < -128); end
      4'd1: begin s = sa - sb; e.r = 8'(ua - ub); e.c = (ua >= ub); e.o = (s > 127) || (s < -128); end
      4'd2: e.r = a ^ b;
      4'd3: e.r = (sa < sb) ? 8'd1 : 8'd0;
      4'd4: e.r = a & b;
      4'd5: e.r = ~(a & b);
      4'd6: e.r = ~(a | b);
      4'd7: e.r = a | b;
      4'd8: e.r = 8'(ua << sh);
      4'd9: e.r = 8'(ua >> sh);
      4'd10: e.r = 8'(sa >>> sh);
      4'd11: begin p = ua * ub; e.r = 8'(p); e.o = (p > 255); end
      default: e.r = '0;
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] c);
    logic got;
    got = 1'b0;
    in_valid = 1'b1; a_i = a; b_i = b; cmd = c;
    for (int t = 0; t < 100 && !got; t++) begin
      #1;
      got = in_ready;
      if (got) sbq.push_back(model(a, b, c));
      @(negedge clk);
      if (!got) out_ready = 1'b1;
    end
    in_valid = 1'b0;
    if (!got) chk("accept_timeout", 0, 1);
  endtask

  always begin
    exp_t e;
    @(negedge clk); #2;
    if (rst_n && out_valid && out_ready) begin
      if (sbq.size() == 0) chk("sb_empty", 1, 0);
      else begin
        e = sbq.pop_front();
        chk("result", result, e.r);
        chk("carryout", carryout, e.c);
        chk("zero", zero, e.z);
        chk("overflow", overflow, e.o);
      end
    end
  end

  initial begin
    int t0;
    #3;
    chk("rst_result", result, 0); chk("rst_valid", out_valid, 0); chk("rst_busy", busy, 0);
    chk("rst_flags", {carryout, zero, overflow}, 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    out_ready = 1'b1;

    send(8'h7F, 8'h01, 4'd0);
    chk("add_lat_valid", out_valid, 1);
    chk("add_res", result, 8'h80); chk("add_ovf", overflow, 1); chk("add_cy", carryout, 0);
    send(8'h05, 8'h05, 4'd1);
    chk("sub_zero", zero, 1); chk("sub_cy", carryout, 1);
    send(8'hFF, 8'h01, 4'd3);
    chk("slt_res", result, 8'h01);
    send(8'h80, 8'h01, 4'd3);
    send(8'h7F, 8'hFF, 4'd1);
    send(8'hC3, 8'h5A, 4'd2);
    send(8'hC3, 8'h5A, 4'd4);
    send(8'hC3, 8'h5A, 4'd5);
    send(8'hC3, 8'h5A, 4'd6);
    send(8'hC3, 8'h5A, 4'd7);
    send(8'h81, 8'h0F, 4'd8);
    send(8'h81, 8'h0F, 4'd9);
    send(8'h81, 8'h0F, 4'd10);
    send(8'h12, 8'h34, 4'd13);

    send(8'h10, 8'h11, 4'd11);
    for (int i = 0; i < W; i++) begin
      chk("mul_busy", busy, 1); chk("mul_in_ready", in_ready, 0); chk("mul_valid", out_valid, 0);
      @(negedge clk);
    end
    chk("mul_lat_valid", out_valid, 1); chk("mul_res", result, 8'h10); chk("mul_ovf", overflow, 1);
    send(8'h03, 8'h05, 4'd11);
    for (int i = 0; i < W; i++) @(negedge clk);
    chk("mul2_res", result, 8'h0F); chk("mul2_ovf", overflow, 0);
    @(negedge clk);

    out_ready = 1'b0;
    send(8'h80, 8'h03, 4'd10);
    for (int i = 0; i < 5; i++) begin
      chk("bp_res", result, 8'hF0); chk("bp_in_ready", in_ready, 0); chk("bp_valid", out_valid, 1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(8'h10, 8'h20, 4'd0);
    chk("bp_update", result, 8'h30);

    t0 = cyc;
    for (int i = 0; i < 10; i++) send(8'(i * 37), 8'(i * 11 + 3), 4'(i % 11));
    chk("throughput", cyc - t0, 10);

    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      send(8'($urandom), 8'($urandom), 4'($urandom_range(0, 15)));
    end
    out_ready = 1'b1;
    for (int i = 0; i < W + 2; i++) @(negedge clk);
    chk("drain1", sbq.size(), 0);

    send(8'hAB, 8'hCD, 4'd11);
    @(negedge clk); @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy, 0); chk("mrst_valid", out_valid, 0); chk("mrst_res", result, 0);
    chk("mrst_flags", {carryout, zero, overflow}, 0);
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_in_ready", in_ready, 1);
    send(8'h01, 8'h01, 4'd0);
    chk("post_rst_add", result, 8'h02);

`ifdef ALU_PIPE_STICKY_OVF_EN
    sticky_clr = 1'b1; @(negedge clk); sticky_clr = 1'b0;
    chk("sticky_cleared", sticky_ovf, 0);
    send(8'h7F, 8'h01, 4'd0);
    for (int i = 0; i < 3; i++) send(8'h01, 8'h01, 4'd0);
    @(negedge clk);
    chk("sticky_hold", sticky_ovf, 1);
    sticky_clr = 1'b1; @(negedge clk); sticky_clr = 1'b0;
    chk("sticky_clr", sticky_ovf, 0);
`endif

    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("drain2", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
